instr_fetch_unit: RTL and testbench

//  Fetch stage in front of decode/immediate_gen. Holds the PC and issues in-order word reads to

---
 rtl/instr_fetch_unit.sv | 195 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues credit-limited in-order imem reads and buffers {pc,instr} for decode.
// With 1-cycle memory an instruction reaches decode two cycles after its request. Optional counters: FETCH_STATS_EN.

module ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_vld) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_vld) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Registered storage only: a pushed entry becomes visible the cycle after the push.
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
endmodule

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_dropped
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fifo_count, pcq_count;
  logic          fifo_empty, pcq_empty;
  logic [63:0]   fifo_head;
  logic [31:0]   pcq_head;
  logic [CW:0]   credit_used;
  logic          req_fire, resp_ok, resp_drop, resp_keep, pop;

  always_comb begin
    pop       = !fifo_empty && id_ready && !redirect_valid;
    resp_ok   = imem_resp_valid && (outstanding_q != '0);
    resp_drop = resp_ok && (drop_cnt_q != '0);
    resp_keep = resp_ok && (drop_cnt_q == '0) && !redirect_valid;
    // The slot freed by this cycle's pop counts as credit; without it a
    // 1-cycle memory could only sustain two instructions every three cycles.
    credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q} - {{CW{1'b0}}, pop};
    imem_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_C);
    req_fire       = imem_req_valid && imem_req_ready;

    pc_d          = pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_ok);
    if (redirect_valid) begin
      pc_d       = redirect_pc & ~32'h3;
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire)  pc_d       = pc_q + 32'd4;
      if (resp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  ifu_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push_vld (req_fire),
    .push_dat (pc_q),
    .pop      (resp_keep),
    .head_dat (pcq_head),
    .count    (pcq_count),
    .empty    (pcq_empty)
  );

  ifu_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fetch_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push_vld (resp_keep),
    .push_dat ({pcq_head, imem_resp_data}),
    .pop      (pop),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign imem_req_addr = pc_q;
  assign id_valid      = !fifo_empty;
  assign id_pc         = fifo_head[63:32];
  assign id_instr      = fifo_head[31:0];

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d, stat_dropped_q, stat_dropped_d;

  always_comb begin
    stat_fetched_d = stat_fetched_q + 32'(pop);
    stat_dropped_d = stat_dropped_q;
    if (redirect_valid) stat_dropped_d = stat_dropped_q + 32'(fifo_count) + 32'(resp_ok);
    else if (resp_drop) stat_dropped_d = stat_dropped_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched_q <= '0;
      stat_dropped_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_dropped_q <= stat_dropped_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_dropped = stat_dropped_q;
`endif

  // Every in-flight response is either owed a PC from the queue or pending discard.
  a_resp_without_req: assert property (@(posedge clk) disable iff (reset)
    !(imem_resp_valid && outstanding_q == '0));
  a_inflight_balance: assert property (@(posedge clk) disable iff (reset)
    (pcq_count + drop_cnt_q) == outstanding_q);
  a_pcq_has_pc: assert property (@(posedge clk) disable iff (reset)
    resp_keep |-> !pcq_empty);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, corner sequences and a randomized run
// checked against a queue-based model of the fetch pipeline and a variable-latency memory.
module tb_instr_fetch_unit;
  localparam logic [31:0] RPC   = 32'h100;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_instr, id_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_dropped;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched    (stat_fetched),
    .stat_dropped    (stat_dropped)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    mem_lat = 1;
  int    last_due = -1;

  typedef struct { logic [31:0] addr; bit dead; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  infl_t       m_inf[$];
  ent_t        m_buf[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetched, m_dropped;

  logic        s_req_v, s_id_v;
  logic [31:0] s_req_addr, s_id_pc, s_id_instr;
`ifdef FETCH_STATS_EN
  logic [31:0] s_fetched, s_dropped;
`endif

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC;
    m_buf.delete();
    m_inf.delete();
    m_fetched = '0;
    m_dropped = '0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance model and memory.
  task automatic step(input bit rst, input bit rdy, input bit redir, input logic [31:0] rpc, input bit mrdy);
    bit    exp_req_v, pop, resp;
    int    d;
    infl_t f;
    @(negedge clk);
    reset          = rst;
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = mrdy;
    if (rst) begin
      mq.delete();
      last_due = -1;
    end
    resp            = (mq.size() > 0) && (mq[0].due == cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? imem_word(mq[0].addr) : 32'h0;
    #1;
    s_req_v    = imem_req_valid;
    s_req_addr = imem_req_addr;
    s_id_v     = id_valid;
    s_id_pc    = id_pc;
    s_id_instr = id_instr;
    pop       = (m_buf.size() > 0) && rdy && !redir;
    exp_req_v = !rst && !redir && ((m_buf.size() - int'(pop) + m_inf.size()) < DEPTH);
    check("req_valid", s_req_v, exp_req_v);
    if (exp_req_v) check("req_addr", s_req_addr, m_pc);
    check("id_valid", s_id_v, m_buf.size() > 0);
    if (m_buf.size() > 0) begin
      check("id_pc", s_id_pc, m_buf[0].pc);
      check("id_instr", s_id_instr, m_buf[0].instr);
    end
`ifdef FETCH_STATS_EN
    s_fetched = stat_fetched;
    s_dropped = stat_dropped;
    check("stat_fetched", s_fetched, m_fetched);
    check("stat_dropped", s_dropped, m_dropped);
`endif
    if (!rst && s_req_v && mrdy) begin
      d = (cyc + mem_lat > last_due + 1) ? cyc + mem_lat : last_due + 1;
      mq.push_back('{addr: s_req_addr, due: d});
      last_due = d;
    end
    if (resp) void'(mq.pop_front());
    if (rst) begin
      model_reset();
    end else if (redir) begin
      m_dropped += 32'(m_buf.size());
      m_buf.delete();
      if (resp && m_inf.size() > 0) begin
        void'(m_inf.pop_front());
        m_dropped++;
      end
      foreach (m_inf[i]) m_inf[i].dead = 1'b1;
      m_pc = rpc & ~32'h3;
    end else begin
      if (pop) begin
        void'(m_buf.pop_front());
        m_fetched++;
      end
      if (resp && m_inf.size() > 0) begin
        f = m_inf.pop_front();
        if (f.dead) m_dropped++;
        else m_buf.push_back('{pc: f.addr, instr: imem_word(f.addr)});
      end
      if (exp_req_v && mrdy) begin
        m_inf.push_back('{addr: m_pc, dead: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  // Two reset cycles; the second samples the state left by the first reset edge.
  task automatic do_reset(input string tag);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check({tag, "_req_valid"}, s_req_v, 1'b0);
    check({tag, "_req_addr"}, s_req_addr, RPC);
    check({tag, "_id_valid"}, s_id_v, 1'b0);
    check({tag, "_id_pc"}, s_id_pc, 32'h0);
    check({tag, "_id_instr"}, s_id_instr, 32'h0);
`ifdef FETCH_STATS_EN
    check({tag, "_stat_fetched"}, s_fetched, 32'h0);
    check({tag, "_stat_dropped"}, s_dropped, 32'h0);
`endif
  endtask

  typedef struct {
    bit          rst_before;
    bit          rdy;
    bit          ev;
    logic [31:0] ea;
    bit          idv;
    logic [31:0] ipc;
  } vec_t;

  initial begin
    vec_t tbl [16];
    bit   seen;
    tbl[0]  = '{1, 1, 1, 32'h100, 0, 32'h0};
    tbl[1]  = '{0, 1, 1, 32'h104, 0, 32'h0};
    tbl[2]  = '{0, 1, 1, 32'h108, 1, 32'h100};
    tbl[3]  = '{0, 1, 1, 32'h10c, 1, 32'h104};
    tbl[4]  = '{0, 1, 1, 32'h110, 1, 32'h108};
    tbl[5]  = '{0, 1, 1, 32'h114, 1, 32'h10c};
    tbl[6]  = '{1, 0, 1, 32'h100, 0, 32'h0};
    tbl[7]  = '{0, 0, 1, 32'h104, 0, 32'h0};
    tbl[8]  = '{0, 0, 0, 32'h0,   1, 32'h100};
    tbl[9]  = '{0, 0, 0, 32'h0,   1, 32'h100};
    tbl[10] = '{0, 0, 0, 32'h0,   1, 32'h100};
    tbl[11] = '{0, 1, 1, 32'h108, 1, 32'h100};
    tbl[12] = '{0, 1, 1, 32'h10c, 1, 32'h104};
    tbl[13] = '{0, 1, 1, 32'h110, 1, 32'h108};
    tbl[14] = '{0, 1, 1, 32'h114, 1, 32'h10c};
    tbl[15] = '{0, 1, 1, 32'h118, 1, 32'h110};

    model_reset();
    mem_lat = 1;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst_before) do_reset("reset");
      step(1'b0, tbl[i].rdy, 1'b0, 32'h0, 1'b1);
      check("tbl_req_valid", s_req_v, tbl[i].ev);
      if (tbl[i].ev) check("tbl_req_addr", s_req_addr, tbl[i].ea);
      check("tbl_id_valid", s_id_v, tbl[i].idv);
      if (tbl[i].idv) begin
        check("tbl_id_pc", s_id_pc, tbl[i].ipc);
        check("tbl_id_instr", s_id_instr, imem_word(tbl[i].ipc));
      end
    end

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset("reset");
    mem_lat = 3;
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
    check("t3_req_in_redirect", s_req_v, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      seen = s_id_v;
    end
    check("t3_id_valid_seen", seen, 1'b1);
    check("t3_id_pc", s_id_pc, 32'h200);
`ifdef FETCH_STATS_EN
    check("t3_stat_dropped", s_dropped, 32'd2);
`endif

    // Redirect coinciding with a response, unaligned target.
    do_reset("reset");
    mem_lat = 1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h203, 1'b1);
    check("t4_req_in_redirect", s_req_v, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t4_id_valid_after", s_id_v, 1'b0);
    check("t4_req_valid_after", s_req_v, 1'b1);
    check("t4_req_addr_after", s_req_addr, 32'h200);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t4_id_pc", s_id_pc, 32'h200);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t5_req_addr_top", s_req_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t5_req_valid_wrap", s_req_v, 1'b1);
    check("t5_req_addr_wrap", s_req_addr, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t5_id_pc_top", s_id_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("t5_id_pc_wrap", s_id_pc, 32'h0);

    // Reset while the buffer is full.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("t6_full_before_reset", s_id_v, 1'b1);
    do_reset("t6");

    // Randomized traffic.
    for (int k = 0; k < 3000 && n_errors <= 50; k++) begin
      bit          rst, redir, rdy, mrdy;
      logic [31:0] rpc;
      if ($urandom_range(0, 19) == 0) mem_lat = $urandom_range(1, 4);
      rst   = ($urandom_range(0, 299) == 0);
      redir = ($urandom_range(0, 24) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      mrdy  = ($urandom_range(0, 3) != 0);
      rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(rst, rdy, redir, rpc, mrdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
